// File: rtl/rv32_csr_pkg.sv
// Shared types and helpers for the Zicsr access controller: opcode and state
// encodings, CSR address field positions and the read-modify-write function.
package rv32_csr_pkg;

  typedef enum logic [2:0] {
    CSR_RW  = 3'b001,
    CSR_RS  = 3'b010,
    CSR_RC  = 3'b011,
    CSR_RWI = 3'b101,
    CSR_RSI = 3'b110,
    CSR_RCI = 3'b111
  } csr_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_RWAIT,
    ST_WRITE,
    ST_RESP
  } csr_state_e;

  localparam int ADDR_PERM_HI = 11;
  localparam int ADDR_PERM_LO = 10;
  localparam int ADDR_PRIV_HI = 9;
  localparam int ADDR_PRIV_LO = 8;

  localparam logic [1:0] PERM_RO = 2'b11;

  localparam logic [1:0] PRIV_U = 2'b00;
  localparam logic [1:0] PRIV_S = 2'b01;
  localparam logic [1:0] PRIV_M = 2'b11;

  // funct3[1:0]==00 is ECALL/EBREAK space or reserved; never a CSR op.
  function automatic logic funct3_is_csr(input logic [2:0] funct3);
    return funct3[1:0] != 2'b00;
  endfunction

  function automatic logic funct3_is_swap(input logic [2:0] funct3);
    return funct3[1:0] == 2'b01;
  endfunction

  function automatic logic [31:0] csr_rmw(input csr_op_e op, input logic [31:0] old,
                                          input logic [31:0] operand);
    logic [31:0] res;
    case (op)
      CSR_RW, CSR_RWI: res = operand;
      CSR_RS, CSR_RSI: res = old | operand;
      CSR_RC, CSR_RCI: res = old & ~operand;
      default:         res = old;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/rv32_csr_access_ctrl.sv
// Sequences one Zicsr instruction at a time onto the single-ported CSR bus:
// legality check, optional read, optional write, then a valid/ready response.
module rv32_csr_access_ctrl
  import rv32_csr_pkg::*;
#(
  parameter int ASYNC_READ = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  priviledge,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_funct3,
  input  logic [11:0] req_addr,
  input  logic [31:0] req_rs1_val,
  input  logic [4:0]  req_rs1_idx,
  input  logic [4:0]  req_rd_idx,
  output logic [11:0] csr_addr,
  output logic        csr_re,
  input  logic [31:0] csr_rdata,
  output logic        csr_we,
  output logic [31:0] csr_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_illegal
);

  csr_state_e  state;
  logic [2:0]  funct3_q;
  logic [11:0] addr_q;
  logic [31:0] operand_q;
  logic [31:0] old_q;
  logic        write_q;
  logic        skip_q;

  logic        wr_req;
  logic        rd_skip;
  logic        illegal;
  logic [31:0] operand;
  logic [31:0] old_val;
  logic [31:0] wdata_next;

  // NOTE: every always_comb output gets a value before any branch, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    wr_req     = funct3_is_swap(req_funct3) || (req_rs1_idx != 5'd0);
    rd_skip    = funct3_is_swap(req_funct3) && (req_rd_idx == 5'd0);
    operand    = req_funct3[2] ? {27'd0, req_rs1_idx} : req_rs1_val;
    illegal    = !funct3_is_csr(req_funct3)
              || (priviledge < req_addr[ADDR_PRIV_HI:ADDR_PRIV_LO])
              || ((req_addr[ADDR_PERM_HI:ADDR_PERM_LO] == PERM_RO) && wr_req);
    old_val    = skip_q ? 32'd0 : csr_rdata;
    wdata_next = csr_rmw(csr_op_e'(funct3_q), old_val, operand_q);
  end

  // NOTE: state and registered outputs use non-blocking assignments so every
  // register samples the pre-edge value of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      req_ready    <= 1'b1;
      csr_addr     <= 12'd0;
      csr_re       <= 1'b0;
      csr_we       <= 1'b0;
      csr_wdata    <= 32'd0;
      resp_valid   <= 1'b0;
      resp_rdata   <= 32'd0;
      resp_illegal <= 1'b0;
      funct3_q     <= 3'd0;
      addr_q       <= 12'd0;
      operand_q    <= 32'd0;
      old_q        <= 32'd0;
      write_q      <= 1'b0;
      skip_q       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            funct3_q  <= req_funct3;
            addr_q    <= req_addr;
            operand_q <= operand;
            write_q   <= wr_req;
            skip_q    <= rd_skip;
            req_ready <= 1'b0;
            if (illegal) begin
              state        <= ST_RESP;
              resp_valid   <= 1'b1;
              resp_illegal <= 1'b1;
              resp_rdata   <= 32'd0;
            end else begin
              state    <= ST_READ;
              csr_addr <= req_addr;
              csr_re   <= !rd_skip;
            end
          end
        end

        ST_READ: begin
          csr_re <= 1'b0;
          if (ASYNC_READ != 0) begin
            old_q     <= old_val;
            csr_we    <= write_q;
            csr_wdata <= write_q ? wdata_next : 32'd0;
            state     <= ST_WRITE;
          end else begin
            state <= ST_RWAIT;
          end
        end

        // Registered CSR file: read data lands one cycle after the strobe.
        ST_RWAIT: begin
          old_q     <= old_val;
          csr_we    <= write_q;
          csr_wdata <= write_q ? wdata_next : 32'd0;
          state     <= ST_WRITE;
        end

        ST_WRITE: begin
          csr_we       <= 1'b0;
          csr_wdata    <= 32'd0;
          csr_addr     <= 12'd0;
          resp_valid   <= 1'b1;
          resp_rdata   <= old_q;
          resp_illegal <= 1'b0;
          state        <= ST_RESP;
        end

        ST_RESP: begin
          if (resp_ready) begin
            resp_valid   <= 1'b0;
            resp_rdata   <= 32'd0;
            resp_illegal <= 1'b0;
            req_ready    <= 1'b1;
            state        <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  logic unused_addr_q;
  assign unused_addr_q = ^addr_q;

endmodule
